// File: rtl/simplez_runctl.sv
// simplez_runctl: run controller and LED trace monitor for the simplez CPU.
// Ports: clk/rst; start; cpu_rstn/cpu_stop/cpu_leds; busy/done/timeout;
//        cycles; trace_count/overflow; rd_addr -> rd_data (comb read).
module simplez_runctl #(
  parameter int RST_CYCLES = 1,
  parameter int TIMEOUT    = 50,
  parameter int CNT_W      = 16,
  parameter int LED_W      = 4,
  parameter int TRACE_AW   = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                cpu_rstn,
  input  logic                cpu_stop,
  input  logic [LED_W-1:0]    cpu_leds,
  output logic                busy,
  output logic                done,
  output logic                timeout,
  output logic [CNT_W-1:0]    cycles,
  output logic [TRACE_AW:0]   trace_count,
  output logic                overflow,
  input  logic [TRACE_AW-1:0] rd_addr,
  output logic [LED_W-1:0]    rd_data
);

  localparam int DEPTH = 1 << TRACE_AW;
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);
  localparam logic [TRACE_AW:0] FULL = {1'b1, {TRACE_AW{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_HALTED,
    S_TIMEOUT
  } state_t;

  state_t            state;
  logic [RW-1:0]     rcnt;
  logic              first;
  logic [LED_W-1:0]  last_leds;
  logic [LED_W-1:0]  mem [DEPTH];

  logic [CNT_W-1:0]  cyc_nx;
  logic              trace_wr;

  assign cyc_nx   = cycles + 1'b1;
  // First RUN cycle always records, later ones only on a change.
  assign trace_wr = first || (cpu_leds != last_leds);

  always_comb begin
    rd_data = '0;
    if ({1'b0, rd_addr} < trace_count)
      rd_data = mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      rcnt        <= '0;
      first       <= 1'b0;
      last_leds   <= '0;
      cpu_rstn    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      cycles      <= '0;
      trace_count <= '0;
      overflow    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_HALTED, S_TIMEOUT: begin
          if (start) begin
            state       <= S_RESET;
            rcnt        <= '0;
            cpu_rstn    <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycles      <= '0;
            trace_count <= '0;
            overflow    <= 1'b0;
          end
        end
        S_RESET: begin
          if (rcnt == RST_LAST) begin
            state    <= S_RUN;
            cpu_rstn <= 1'b1;
            cycles   <= '0;
            first    <= 1'b1;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        S_RUN: begin
          cycles    <= cyc_nx;
          first     <= 1'b0;
          last_leds <= cpu_leds;
          if (trace_wr) begin
            if (trace_count == FULL) begin
              overflow <= 1'b1;
            end else begin
              mem[trace_count[TRACE_AW-1:0]] <= cpu_leds;
              trace_count <= trace_count + 1'b1;
            end
          end
          // Stop takes priority over a coincident timeout.
          if (cpu_stop) begin
            state <= S_HALTED;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (cyc_nx == TO) begin
            state    <= S_TIMEOUT;
            busy     <= 1'b0;
            timeout  <= 1'b1;
            cpu_rstn <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simplez_runctl.sv
// tb_simplez_runctl: directed bench for simplez_runctl.
// RST_CYCLES=2, TIMEOUT=50, TRACE_AW=3.
module tb_simplez_runctl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        cpu_rstn;
  logic        cpu_stop;
  logic [3:0]  cpu_leds;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [15:0] cycles;
  logic [3:0]  trace_count;
  logic        overflow;
  logic [2:0]  rd_addr;
  logic [3:0]  rd_data;

  int errors = 0;
  int checks = 0;

  simplez_runctl #(
    .RST_CYCLES(2),
    .TIMEOUT(50),
    .CNT_W(16),
    .LED_W(4),
    .TRACE_AW(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .cpu_rstn(cpu_rstn),
    .cpu_stop(cpu_stop),
    .cpu_leds(cpu_leds),
    .busy(busy),
    .done(done),
    .timeout(timeout),
    .cycles(cycles),
    .trace_count(trace_count),
    .overflow(overflow),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [3:0] exp);
    rd_addr = a;
    #1;
    chk($sformatf("rd%0d", a), rd_data, exp);
  endtask

  // Pulse start, then count cycles with cpu_rstn low until RUN.
  task automatic start_run(output int n);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!cpu_rstn && n < 20) begin
      n++;
      tick();
    end
    if (n >= 20) chk("run_entry_bound", 0, 1);
  endtask

  task automatic run_cycle(input logic [3:0] l, input logic s);
    cpu_leds = l;
    cpu_stop = s;
    tick();
    cpu_stop = 1'b0;
  endtask

  int n;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    cpu_stop = 1'b0;
    cpu_leds = '0;
    rd_addr = '0;
    tick();
    tick();
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      chk("idle_status",
          {27'd0, cpu_rstn, busy, done, timeout, overflow}, 0);
    end
    chk("idle_cycles", cycles, 0);
    chk("idle_tcount", trace_count, 0);
    chk("idle_rd", rd_data, 0);

    // Normal halt: leds 0,0,1,1,3,3,3 with stop on RUN cycle 7.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("reset_busy", busy, 1);
    n = 1;
    while (!cpu_rstn && n < 20) begin
      tick();
      if (!cpu_rstn) n++;
    end
    chk("rstn_low_len", n, 2);
    run_cycle(4'd0, 1'b0);
    run_cycle(4'd0, 1'b0);
    run_cycle(4'd1, 1'b0);
    run_cycle(4'd1, 1'b0);
    run_cycle(4'd3, 1'b0);
    chk("run_busy", busy, 1);
    chk("run_cycles", cycles, 5);
    run_cycle(4'd3, 1'b0);
    run_cycle(4'd3, 1'b1);
    chk("halt_done", done, 1);
    chk("halt_busy", busy, 0);
    chk("halt_rstn", cpu_rstn, 1);
    chk("halt_cycles", cycles, 7);
    chk("halt_tcount", trace_count, 3);
    rd(3'd0, 4'd0);
    rd(3'd1, 4'd1);
    rd(3'd2, 4'd3);
    rd(3'd3, 4'd0);

    // Restart from HALTED clears trace; overflow run.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_tcount", trace_count, 0);
    chk("restart_rstn", cpu_rstn, 0);
    chk("restart_done", done, 0);
    n = 0;
    while (!cpu_rstn && n < 20) begin
      n++;
      tick();
    end
    for (int i = 1; i <= 12; i++) begin
      run_cycle(4'(i), i == 12);
    end
    chk("ovf_done", done, 1);
    chk("ovf_cycles", cycles, 12);
    chk("ovf_tcount", trace_count, 8);
    chk("ovf_flag", overflow, 1);
    rd(3'd0, 4'd1);
    rd(3'd4, 4'd5);
    rd(3'd7, 4'd8);

    // Timeout run; start pulse during RUN must be ignored.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_ovf", overflow, 0);
    n = 0;
    while (!cpu_rstn && n < 20) begin
      n++;
      tick();
    end
    for (int i = 1; i <= 49; i++) begin
      start = (i == 10);
      run_cycle(4'd5, 1'b0);
      start = 1'b0;
    end
    chk("pre_to_busy", busy, 1);
    chk("pre_to_cycles", cycles, 49);
    run_cycle(4'd5, 1'b0);
    chk("to_flag", timeout, 1);
    chk("to_done", done, 0);
    chk("to_busy", busy, 0);
    chk("to_rstn", cpu_rstn, 0);
    chk("to_cycles", cycles, 50);
    chk("to_tcount", trace_count, 1);
    rd(3'd0, 4'd5);

    // Stop and timeout on the same cycle: stop wins.
    start_run(n);
    chk("coll_clear_to", timeout, 0);
    for (int i = 1; i <= 50; i++) begin
      run_cycle(4'd2, i == 50);
    end
    chk("coll_done", done, 1);
    chk("coll_to", timeout, 0);
    chk("coll_cycles", cycles, 50);

    // Reset in the middle of a run.
    start_run(n);
    for (int i = 1; i <= 5; i++) begin
      run_cycle(4'(i), 1'b0);
    end
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rstn", cpu_rstn, 0);
    chk("mid_busy_clr", busy, 0);
    chk("mid_cycles", cycles, 0);
    chk("mid_tcount", trace_count, 0);
    tick();
    chk("mid_idle", {busy, done, timeout, cpu_rstn}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
